// File: rtl/aoi_pkg.sv
// aoi_pkg: shared constants for the aoi_pipe AND-OR-INVERT / OR-AND-INVERT array.
//   AOI_MODE / OAI_MODE : per-beat mode encodings carried alongside the data
//   DEF_CH / DEF_GROUPS / DEF_TERM : default geometry, the classic ~(a&b | c&d)
//   CNT_W : width of the optional accepted-beat counter (AOI_PIPE_CNT_EN)
package aoi_pkg;

  localparam logic AOI_MODE = 1'b0;
  localparam logic OAI_MODE = 1'b1;

  localparam int DEF_CH     = 4;
  localparam int DEF_GROUPS = 2;
  localparam int DEF_TERM   = 2;

  localparam int CNT_W = 16;

endpackage

// File: rtl/aoi_cell.sv
// aoi_cell: combinational slice for one output channel, split into the two
// halves that sit on either side of the first pipeline register.
//   term_mode  in  1               mode of the beat being formed into terms
//   term_in    in  GROUPS*TERM     operand bits, bit g*TERM+t is input t of term g
//   term_out   out GROUPS          AND terms (AOI) or OR terms (OAI)
//   red_mode   in  1               mode of the beat being reduced
//   red_in     in  GROUPS          registered term bits
//   red_out    out 1               inverted OR (AOI) or inverted AND (OAI)
module aoi_cell
  import aoi_pkg::*;
#(
  parameter int GROUPS = DEF_GROUPS,
  parameter int TERM   = DEF_TERM
) (
  input  logic                     term_mode,
  input  logic [GROUPS*TERM-1:0]   term_in,
  output logic [GROUPS-1:0]        term_out,
  input  logic                     red_mode,
  input  logic [GROUPS-1:0]        red_in,
  output logic                     red_out
);

  // Term generation: the inner gate of the pair flips between AND and OR
  // with the mode, so each term reduces its own TERM-wide slice.
  always_comb begin
    term_out = '0;
    for (int g = 0; g < GROUPS; g++) begin
      if (term_mode == OAI_MODE)
        term_out[g] = |term_in[g*TERM +: TERM];
      else
        term_out[g] = &term_in[g*TERM +: TERM];
    end
  end

  // Reduction and inversion: the outer gate is the dual of the inner one.
  always_comb begin
    red_out = 1'b0;
    if (red_mode == OAI_MODE)
      red_out = ~(&red_in);
    else
      red_out = ~(|red_in);
  end

endmodule

// File: rtl/aoi_pipe.sv
// aoi_pipe: two-stage valid/ready pipelined AOI/OAI array.
// Stage 1 holds the term bits and mode of one beat; stage 2 holds the
// reduced, inverted result. Up to two beats can be in flight.
//   clk        in  1               rising-edge clock
//   rst_n      in  1               asynchronous active-low reset
//   in_valid   in  1               input beat valid
//   in_ready   out 1               block can accept a beat this cycle
//   in_mode    in  1               0 = AOI, 1 = OAI, travels with in_data
//   in_data    in  CH*GROUPS*TERM  bit (c*GROUPS+g)*TERM+t = input t, term g, channel c
//   out_valid  out 1               result valid
//   out_ready  in  1               consumer accepts result
//   out_data   out CH              bit c = result of channel c
//   txn_cnt    out 16              saturating accepted-beat count
// Optional feature macro: AOI_PIPE_CNT_EN adds txn_cnt and its counter.
module aoi_pipe
  import aoi_pkg::*;
#(
  parameter int CH     = DEF_CH,
  parameter int GROUPS = DEF_GROUPS,
  parameter int TERM   = DEF_TERM
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_mode,
  input  logic [CH*GROUPS*TERM-1:0]  in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CH-1:0]              out_data
`ifdef AOI_PIPE_CNT_EN
  ,
  output logic [CNT_W-1:0]           txn_cnt
`endif
);

  logic                   s1_valid;
  logic                   s1_mode;
  logic [CH*GROUPS-1:0]   s1_terms;
  logic [CH*GROUPS-1:0]   term_next;
  logic [CH-1:0]          red_next;
  logic                   s2_load;
  logic                   accept;

  // Stage 2 can take a new value whenever its current result is absent or
  // leaving; stage 1 can refill whenever it is empty or draining into stage 2.
  // in_ready never looks at in_valid.
  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign accept   = in_valid && in_ready;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    aoi_cell #(
      .GROUPS (GROUPS),
      .TERM   (TERM)
    ) u_cell (
      .term_mode (in_mode),
      .term_in   (in_data[c*GROUPS*TERM +: GROUPS*TERM]),
      .term_out  (term_next[c*GROUPS +: GROUPS]),
      .red_mode  (s1_mode),
      .red_in    (s1_terms[c*GROUPS +: GROUPS]),
      .red_out   (red_next[c])
    );
  end

  // Stage 1. s1_valid follows in_valid whenever the stage advances, so it
  // clears only when its beat actually moves into stage 2. Payload is only
  // written on an accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= AOI_MODE;
      s1_terms <= '0;
    end else begin
      if (in_ready)
        s1_valid <= in_valid;
      if (accept) begin
        s1_mode  <= in_mode;
        s1_terms <= term_next;
      end
    end
  end

  // Stage 2. Holding while stalled keeps out_data/out_valid stable until
  // the consumer takes the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid)
        out_data <= red_next;
    end
  end

`ifdef AOI_PIPE_CNT_EN
  // Accepted-beat counter, sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      txn_cnt <= '0;
    else if (accept && (txn_cnt != {CNT_W{1'b1}}))
      txn_cnt <= txn_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_aoi_pipe.sv
// tb_aoi_pipe: directed, table-driven bench for aoi_pipe at default geometry.
// Inputs change and outputs are sampled on the falling clock edge.
// Build with AOI_PIPE_CNT_EN defined to also exercise txn_cnt.
module tb_aoi_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_mode;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
`ifdef AOI_PIPE_CNT_EN
  logic [15:0] txn_cnt;
`endif

  int total_cnt = 0;
  int bad_cnt   = 0;

  typedef struct {
    logic        mode;
    logic [15:0] data;
    logic [3:0]  exp;
  } vec_t;

  vec_t vecs[20];

  aoi_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef AOI_PIPE_CNT_EN
    ,
    .txn_cnt   (txn_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: four channels of ~(a&b | c&d) or ~((a|b)&(c|d)).
  function automatic logic [3:0] ref_model(input logic mode, input logic [15:0] d);
    logic [3:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      if (mode)
        r[c] = ~((d[4*c] | d[4*c+1]) & (d[4*c+2] | d[4*c+3]));
      else
        r[c] = ~((d[4*c] & d[4*c+1]) | (d[4*c+2] & d[4*c+3]));
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One isolated beat with out_ready high: not valid after the accept edge,
  // valid with the result after the following edge, then consumed.
  task automatic applyStimulus(input logic mode, input logic [15:0] data,
                               input logic [3:0] exp, input string name);
    @(negedge clk);
    in_mode  = mode;
    in_data  = data;
    in_valid = 1'b1;
    checkOutput({name, "_ready"}, 16'(in_ready), 16'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput({name, "_early"}, 16'(out_valid), 16'h0);
    @(posedge clk);
    #1;
    checkOutput({name, "_valid"}, 16'(out_valid), 16'h1);
    checkOutput({name, "_data"}, 16'(out_data), 16'(exp));
    @(posedge clk);
    #1;
    checkOutput({name, "_drained"}, 16'(out_valid), 16'h0);
  endtask

`ifdef AOI_PIPE_CNT_EN
  task automatic streamBeats(input int n);
    @(negedge clk);
    out_ready = 1'b1;
    in_mode   = 1'b0;
    in_data   = 16'h0;
    in_valid  = 1'b1;
    repeat (n) @(negedge clk);
    in_valid = 1'b0;
  endtask
`endif

  initial begin
    logic [15:0] bp_data[4];
    logic [3:0]  bp_exp[$];
    int          idx;

    // Vector table: exhaustive channel 0 in AOI, then the mode corners.
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = 4'(i);
      vecs[i].mode = 1'b0;
      vecs[i].data = 16'(i);
      vecs[i].exp  = {3'b111, ~((v[0] & v[1]) | (v[2] & v[3]))};
    end
    vecs[16] = '{1'b1, 16'h0000, 4'hF};
    vecs[17] = '{1'b0, 16'hFFFF, 4'h0};
    vecs[18] = '{1'b1, 16'hFFFF, 4'h0};
    vecs[19] = '{1'b0, 16'h0003, 4'b1110};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_data   = 16'h0;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", 16'(out_valid), 16'h0);
    checkOutput("rst_out_data", 16'(out_data), 16'h0);
    checkOutput("rst_in_ready", 16'(in_ready), 16'h1);
`ifdef AOI_PIPE_CNT_EN
    checkOutput("rst_txn_cnt", txn_cnt, 16'h0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_in_ready", 16'(in_ready), 16'h1);

    foreach (vecs[i])
      applyStimulus(vecs[i].mode, vecs[i].data, vecs[i].exp, $sformatf("vec%0d", i));

    // Backpressure: offer four beats with the consumer stalled.
    $display("[TB] backpressure");
    bp_data[0] = 16'h0003;
    bp_data[1] = 16'h00F0;
    bp_data[2] = 16'hFFFF;
    bp_data[3] = 16'h5555;
    idx = 0;
    @(negedge clk);
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      in_valid = 1'b1;
      in_mode  = 1'b0;
      in_data  = bp_data[idx];
      if (cyc >= 2) begin
        checkOutput("bp_ready_low", 16'(in_ready), 16'h0);
        checkOutput("bp_hold_valid", 16'(out_valid), 16'h1);
        checkOutput("bp_hold_data", 16'(out_data), 16'(ref_model(1'b0, bp_data[0])));
      end
      if (in_ready) begin
        bp_exp.push_back(ref_model(1'b0, bp_data[idx]));
        idx++;
      end
      @(negedge clk);
    end
    checkOutput("bp_accepts", 16'(idx), 16'd2);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("bp_drain%0d_valid", k), 16'(out_valid), 16'h1);
      checkOutput($sformatf("bp_drain%0d_data", k), 16'(out_data), 16'(bp_exp.pop_front()));
      @(negedge clk);
    end
    checkOutput("bp_drained", 16'(out_valid), 16'h0);

    // Throughput: eight back-to-back beats, alternating mode.
    $display("[TB] throughput");
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc < 8) begin
        in_valid = 1'b1;
        in_mode  = cyc[0];
        in_data  = 16'h1357 * 16'(cyc + 1);
        checkOutput($sformatf("tp_ready%0d", cyc), 16'(in_ready), 16'h1);
      end else begin
        in_valid = 1'b0;
      end
      if (cyc >= 2 && cyc < 10) begin
        checkOutput($sformatf("tp_valid%0d", cyc), 16'(out_valid), 16'h1);
        checkOutput($sformatf("tp_data%0d", cyc), 16'(out_data),
                    16'(ref_model(1'((cyc - 2) % 2), 16'h1357 * 16'(cyc - 1))));
      end else begin
        checkOutput($sformatf("tp_idle%0d", cyc), 16'(out_valid), 16'h0);
      end
      @(negedge clk);
    end

    // Reset with two beats in flight.
    $display("[TB] reset mid-stream");
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 1'b0;
    in_data   = 16'h0000;
    @(negedge clk);
    in_data = 16'h000F;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("mid_pre_valid", 16'(out_valid), 16'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 16'(out_valid), 16'h0);
    checkOutput("mid_rst_ready", 16'(in_ready), 16'h1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("mid_no_stale%0d", k), 16'(out_valid), 16'h0);
    end
    checkOutput("mid_post_ready", 16'(in_ready), 16'h1);
    applyStimulus(1'b1, 16'h8421, ref_model(1'b1, 16'h8421), "mid_after");

`ifdef AOI_PIPE_CNT_EN
    $display("[TB] counter");
    checkOutput("cnt_one", txn_cnt, 16'd1);
    streamBeats(65533);
    checkOutput("cnt_fffe", txn_cnt, 16'hFFFE);
    streamBeats(3);
    checkOutput("cnt_sat", txn_cnt, 16'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
